// File: rtl/seek_controller.sv
// Floppy head seek/recalibrate sequencer: drives step/dir with fixed timing, tracks cylinder, homes on track 0.
// Latency: accept->done = 2 + DIR_SETUP + n*(LOW+GAP) + SETTLE cycles for an n-track seek; cmd_ready only in IDLE.
// Backpressure: cmd_valid is ignored while busy; commands are not queued.
module seek_controller #(
    parameter int unsigned STEP_LOW_CYCLES  = 500,
    parameter int unsigned STEP_GAP_CYCLES  = 3000,
    parameter int unsigned DIR_SETUP_CYCLES = 16,
    parameter int unsigned SETTLE_CYCLES    = 15000,
    parameter int unsigned MAX_TRACK        = 79,
    parameter int unsigned RECAL_LIMIT      = 85
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_recal,
    input  logic [7:0] cmd_track,
    input  logic       tr0,
    output logic       step,
    output logic       dir,
    output logic [7:0] cur_track,
    output logic       homed,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE, CHECK, DIR_SETUP, PULSE_LO, PULSE_HI, SETTLE, FINISH
    } state_t;

    localparam logic [15:0] T_DIR    = 16'(DIR_SETUP_CYCLES - 1);
    localparam logic [15:0] T_LOW    = 16'(STEP_LOW_CYCLES - 1);
    localparam logic [15:0] T_GAP    = 16'(STEP_GAP_CYCLES - 1);
    localparam logic [15:0] T_SETTLE = 16'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  MAX_TRK  = 8'(MAX_TRACK);
    localparam logic [7:0]  LIMIT    = 8'(RECAL_LIMIT);

    state_t      state, state_nxt;
    logic [15:0] timer, timer_load;
    logic        tr0_m, tr0_s;
    logic        recal_r;
    logic [7:0]  target_r;
    logic [7:0]  step_cnt;
    logic        fail_r;
    logic        timer_zero, at_target, seek_bad, step_limit;

    assign timer_zero = (timer == 16'd0);
    assign at_target  = (cur_track == target_r);
    assign seek_bad   = !homed || (target_r > MAX_TRK);
    assign step_limit = (step_cnt == LIMIT);

    // State register plus timer, reloaded on every state change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            timer <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                timer <= timer_load;
            else if (!timer_zero)
                timer <= timer - 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (cmd_valid) state_nxt = CHECK;
            CHECK: begin
                if (recal_r)
                    state_nxt = tr0_s ? SETTLE : DIR_SETUP;
                else if (seek_bad || at_target)
                    state_nxt = FINISH;
                else
                    state_nxt = DIR_SETUP;
            end
            DIR_SETUP: if (timer_zero) state_nxt = PULSE_LO;
            PULSE_LO:  if (timer_zero) state_nxt = PULSE_HI;
            PULSE_HI: begin
                if (timer_zero) begin
                    if (recal_r) begin
                        if (tr0_s)           state_nxt = SETTLE;
                        else if (step_limit) state_nxt = FINISH;
                        else                 state_nxt = PULSE_LO;
                    end else begin
                        state_nxt = at_target ? SETTLE : PULSE_LO;
                    end
                end
            end
            SETTLE:    if (timer_zero) state_nxt = FINISH;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        timer_load = 16'd0;
        case (state_nxt)
            DIR_SETUP: timer_load = T_DIR;
            PULSE_LO:  timer_load = T_LOW;
            PULSE_HI:  timer_load = T_GAP;
            SETTLE:    timer_load = T_SETTLE;
            default:   timer_load = 16'd0;
        endcase
    end

    // Datapath: synchronizer, command latch, position tracking, registered step/dir.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tr0_m     <= 1'b0;
            tr0_s     <= 1'b0;
            recal_r   <= 1'b0;
            target_r  <= 8'd0;
            step_cnt  <= 8'd0;
            fail_r    <= 1'b0;
            cur_track <= 8'd0;
            homed     <= 1'b0;
            dir       <= 1'b1;
            step      <= 1'b1;
        end else begin
            tr0_m <= tr0;
            tr0_s <= tr0_m;
            // Step follows next state so it is a clean flop output, low only in PULSE_LO.
            step  <= (state_nxt != PULSE_LO);

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        recal_r  <= cmd_recal;
                        target_r <= cmd_track;
                    end
                end
                CHECK: begin
                    if (recal_r) begin
                        dir      <= 1'b1;
                        step_cnt <= 8'd0;
                        fail_r   <= 1'b0;
                        if (tr0_s) begin
                            cur_track <= 8'd0;
                            homed     <= 1'b1;
                        end
                    end else begin
                        fail_r <= seek_bad;
                        if (!seek_bad && !at_target)
                            dir <= (target_r < cur_track);
                    end
                end
                PULSE_LO: begin
                    if (timer_zero) begin
                        if (recal_r)
                            step_cnt <= step_cnt + 8'd1;
                        else if (dir) begin
                            if (cur_track != 8'd0) cur_track <= cur_track - 8'd1;
                        end else begin
                            if (cur_track != 8'hFF) cur_track <= cur_track + 8'd1;
                        end
                    end
                end
                PULSE_HI: begin
                    if (timer_zero && recal_r) begin
                        if (tr0_s) begin
                            cur_track <= 8'd0;
                            homed     <= 1'b1;
                        end else if (step_limit) begin
                            homed  <= 1'b0;
                            fail_r <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == FINISH);
        err       = (state == FINISH) && fail_r;
    end

endmodule

// File: tb/tb_seek_controller.sv
// Directed bench for seek_controller with shortened timing parameters.
// Pulse shape and direction are watched by a negedge monitor that is cleared per command.
module tb_seek_controller;

    localparam int L = 50;
    localparam int G = 30;
    localparam int D = 16;
    localparam int S = 100;
    localparam int T = L + G;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_recal;
    logic [7:0] cmd_track;
    logic       tr0;
    logic       step;
    logic       dir;
    logic [7:0] cur_track;
    logic       homed;
    logic       busy;
    logic       done;
    logic       err;

    seek_controller #(
        .STEP_LOW_CYCLES (L),
        .STEP_GAP_CYCLES (G),
        .DIR_SETUP_CYCLES(D),
        .SETTLE_CYCLES   (S),
        .MAX_TRACK       (79),
        .RECAL_LIMIT     (85)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_recal(cmd_recal),
        .cmd_track(cmd_track),
        .tr0      (tr0),
        .step     (step),
        .dir      (dir),
        .cur_track(cur_track),
        .homed    (homed),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    logic mon_clr  = 1'b0;
    int   rises, lo_bad, gap_bad, low_len, high_len;
    logic seen0, seen1, step_p;

    // Step waveform monitor: counts rising edges, checks low width and inter-pulse gap, records dir while low.
    always @(negedge clk) begin
        step_p <= step;
        if (mon_clr) begin
            rises <= 0; lo_bad <= 0; gap_bad <= 0;
            low_len <= 0; high_len <= 0;
            seen0 <= 1'b0; seen1 <= 1'b0;
        end else if (!step) begin
            low_len  <= low_len + 1;
            high_len <= 0;
            if (dir) seen1 <= 1'b1; else seen0 <= 1'b1;
            if (step_p && rises > 0 && high_len != G) gap_bad <= gap_bad + 1;
        end else begin
            high_len <= high_len + 1;
            low_len  <= 0;
            if (!step_p) begin
                rises <= rises + 1;
                if (low_len != L) lo_bad <= lo_bad + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic recal, input logic [7:0] trk);
        @(negedge clk);
        chk("cmd_ready_before_cmd", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_recal = recal;
        cmd_track = trk;
        mon_clr   = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_recal = 1'b0;
        cmd_track = 8'hAA;
        mon_clr   = 1'b0;
    endtask

    // lat counts clock edges after the accepting edge until done is seen.
    task automatic wait_done(input int budget, output int lat, output logic e);
        logic got;
        got = 1'b0;
        lat = 0;
        e   = 1'b0;
        while (!got && lat < budget) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) begin
                got = 1'b1;
                e   = err;
            end
        end
        chk("done_seen", 32'(got), 1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_after_done", 32'(cmd_ready), 1);
    endtask

    task automatic wait_rises(input int n, input int budget);
        int k;
        k = 0;
        while (rises < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("rises_reached", 32'(rises >= n), 1);
    endtask

    initial begin
        int   lat;
        logic e;

        rst = 1'b0; cmd_valid = 1'b0; cmd_recal = 1'b0; cmd_track = 8'd0; tr0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_step", 32'(step), 1);
        chk("rst_dir", 32'(dir), 1);
        chk("rst_cur_track", 32'(cur_track), 0);
        chk("rst_homed", 32'(homed), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk);
        rst = 1'b1;

        // Seek before homing fails immediately without motion.
        do_cmd(1'b0, 8'd10);
        wait_done(50, lat, e);
        chk("unhomed_lat", 32'(lat), 1);
        chk("unhomed_err", 32'(e), 1);
        chk("unhomed_rises", 32'(rises), 0);
        chk("unhomed_homed", 32'(homed), 0);
        chk("unhomed_track", 32'(cur_track), 0);

        // Recalibrate: sensor appears during the third gap.
        do_cmd(1'b1, 8'd0);
        wait_rises(3, 2000);
        tr0 = 1'b1;
        wait_done(2000, lat, e);
        chk("recal_err", 32'(e), 0);
        chk("recal_rises", 32'(rises), 3);
        chk("recal_lo_width", 32'(lo_bad), 0);
        chk("recal_gap_width", 32'(gap_bad), 0);
        chk("recal_dir_toward_edge", 32'(seen0), 0);
        chk("recal_homed", 32'(homed), 1);
        chk("recal_track", 32'(cur_track), 0);
        tr0 = 1'b0;

        // Seek 0 -> 5.
        do_cmd(1'b0, 8'd5);
        wait_done(5000, lat, e);
        chk("seek5_lat", 32'(lat), 32'(1 + D + 5 * T + S));
        chk("seek5_err", 32'(e), 0);
        chk("seek5_rises", 32'(rises), 5);
        chk("seek5_lo_width", 32'(lo_bad), 0);
        chk("seek5_gap_width", 32'(gap_bad), 0);
        chk("seek5_dir_center", 32'(seen1), 0);
        chk("seek5_dir_end", 32'(dir), 0);
        chk("seek5_track", 32'(cur_track), 5);

        // Seek 5 -> 2.
        do_cmd(1'b0, 8'd2);
        wait_done(5000, lat, e);
        chk("seek2_lat", 32'(lat), 32'(1 + D + 3 * T + S));
        chk("seek2_rises", 32'(rises), 3);
        chk("seek2_dir_edge", 32'(seen0), 0);
        chk("seek2_dir_end", 32'(dir), 1);
        chk("seek2_track", 32'(cur_track), 2);

        // Seek to current cylinder: done two cycles after accept, nothing moves.
        do_cmd(1'b0, 8'd2);
        wait_done(50, lat, e);
        chk("same_lat", 32'(lat), 1);
        chk("same_err", 32'(e), 0);
        chk("same_rises", 32'(rises), 0);

        // Target beyond the last cylinder.
        do_cmd(1'b0, 8'd80);
        wait_done(50, lat, e);
        chk("over_err", 32'(e), 1);
        chk("over_rises", 32'(rises), 0);
        chk("over_track", 32'(cur_track), 2);
        chk("over_homed", 32'(homed), 1);

        // Reset asserted while step is low during a seek 2 -> 40.
        do_cmd(1'b0, 8'd40);
        wait_rises(2, 2000);
        while (step && rises < 5) begin
            @(negedge clk);
            #1;
        end
        chk("midrst_step_low", 32'(step), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_step", 32'(step), 1);
        chk("midrst_dir", 32'(dir), 1);
        chk("midrst_track", 32'(cur_track), 0);
        chk("midrst_homed", 32'(homed), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_err", 32'(err), 0);
        @(negedge clk);
        rst = 1'b1;

        // Recalibrate with the sensor never asserting.
        do_cmd(1'b1, 8'd0);
        wait_done(8000, lat, e);
        chk("recalfail_lat", 32'(lat), 32'(1 + D + 85 * T));
        chk("recalfail_err", 32'(e), 1);
        chk("recalfail_rises", 32'(rises), 85);
        chk("recalfail_lo_width", 32'(lo_bad), 0);
        chk("recalfail_homed", 32'(homed), 0);

        // Homing lost, so a seek must fail again.
        do_cmd(1'b0, 8'd3);
        wait_done(50, lat, e);
        chk("lost_home_err", 32'(e), 1);
        chk("lost_home_rises", 32'(rises), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
